id_ex_operand_stage: RTL

- Decode-to-execute pipeline register that builds ALU operands and holds them for the 64-bit ALU.
- Captures register-file read data, immediate and ALU control each instruction.
- Resolves operand forwarding from the EX/MEM and MEM/WB stages before capture.
- Presents registered src1/src2/ctrl plus writeback tags to the ALU stage under a valid/ready handshake, with flush for branch redirect.

---
 rtl/id_ex_operand_stage.sv | 99 +++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with operand forwarding and valid/ready handshake
module id_ex_operand_stage #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              alu_src_i,
  input  logic [CTRL_W-1:0] alu_ctrl_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              reg_write_i,
  input  logic              flush_i,
  input  logic              exmem_reg_write_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic              memwb_reg_write_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] src1_o,
  output logic [DATA_W-1:0] src2_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              reg_write_o
);

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  logic [DATA_W-1:0] fwd1;
  logic [DATA_W-1:0] fwd2;
  logic              capture;

  // Stage accepts whenever it is empty or its entry is being consumed this cycle
  assign in_ready_o = !out_valid_o || out_ready_i;
  assign capture    = in_valid_i && in_ready_o && !flush_i;

  // Source 1 forwarding: x0 reads zero, EX/MEM beats MEM/WB, else register file
  always_comb begin
    fwd1 = rs1_data_i;
    if (rs1_addr_i == ZERO_REG) begin
      fwd1 = '0;
    end else if (exmem_reg_write_i && (exmem_rd_i == rs1_addr_i)) begin
      fwd1 = exmem_result_i;
    end else if (memwb_reg_write_i && (memwb_rd_i == rs1_addr_i)) begin
      fwd1 = memwb_data_i;
    end
  end

  // Source 2 forwarding: same priority as source 1
  always_comb begin
    fwd2 = rs2_data_i;
    if (rs2_addr_i == ZERO_REG) begin
      fwd2 = '0;
    end else if (exmem_reg_write_i && (exmem_rd_i == rs2_addr_i)) begin
      fwd2 = exmem_result_i;
    end else if (memwb_reg_write_i && (memwb_rd_i == rs2_addr_i)) begin
      fwd2 = memwb_data_i;
    end
  end

  // Pipeline register: flush kills the slot, capture loads it, a bare consume empties it
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_valid_o  <= 1'b0;
      src1_o       <= '0;
      src2_o       <= '0;
      ctrl_o       <= '0;
      store_data_o <= '0;
      rd_addr_o    <= '0;
      reg_write_o  <= 1'b0;
    end else if (flush_i) begin
      // Payload other than the write enable keeps its last value
      out_valid_o <= 1'b0;
      reg_write_o <= 1'b0;
    end else if (capture) begin
      out_valid_o  <= 1'b1;
      src1_o       <= fwd1;
      src2_o       <= alu_src_i ? imm_i : fwd2;
      ctrl_o       <= alu_ctrl_i;
      store_data_o <= fwd2;
      rd_addr_o    <= rd_addr_i;
      reg_write_o  <= reg_write_i;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
      reg_write_o <= 1'b0;
    end
  end

endmodule
